if_fetch: RTL
=============

# if_fetch

Instruction-fetch responder that sits between the PC register and the ID stage. It accepts the fetch address and chip-enable from the PC register and reads the 32-bit instruction from the shared byte-wide RAM port as four sequential byte reads. A small direct-mapped instruction cache sits in front of RAM. While a fetch is outstanding the block requests a pipeline stall, so the PC holds.

## Interface
- ICACHE_IDX, 6: log2 of cache lines; each line holds one instruction.
- clk_in  in  1  clock; all state changes on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- ce_in  in  1  fetch enable from PC register.
- pc_in  in  32  fetch address, word-aligned.
- branch_flag_in  in  1  flush: abort any in-flight fetch.
- stall  in  6  pipeline stall vector; stall[1] high means ID is stalled.
- mem_grant_in  in  1  RAM port granted to fetch this cycle.
- mem_din_in  in  8  RAM read byte for the address issued the previous cycle.
- mem_req_out  out  1  fetch wants the RAM port.
- mem_a_out  out  32  RAM byte address.
- mem_wr_out  out  1  always 0 (read only).
- stall_req_out  out  1  fetch busy; PC must hold.
- inst_valid_out  out  1  inst_out/inst_pc_out valid.
- inst_out  out  32  fetched instruction.
- inst_pc_out  out  32  address of inst_out.

## Operation
- Lookup: index = pc_in[ICACHE_IDX+1:2], tag = pc_in[31:ICACHE_IDX+2]. Hit = valid[index] and tag match.
- FSM states: IDLE, FETCH, DONE.
- IDLE, ce_in=1, hit: the next edge loads inst_out with the cached word, loads inst_pc_out with pc_in, and sets inst_valid_out=1. stall_req_out stays 0.
- IDLE, ce_in=1, miss: stall_req_out=1 combinationally in the same cycle. Latch pc_in to fetch_pc, clear the issue count and receive count, go to FETCH.
- FETCH:
  - While issue count is below 4: mem_req_out=1, mem_a_out = fetch_pc + issue count.
  - If mem_grant_in=1, issue count increments and a pending flag is set for the next cycle.
  - When the pending flag is set, mem_din_in is written into byte lane [receive count] (little-endian: byte at fetch_pc goes to bits 7:0), and receive count increments.
  - Once all 4 bytes are received: write the cache line (valid, tag, data) and go to DONE.
- DONE: load inst_out, inst_pc_out=fetch_pc, inst_valid_out=1, return to IDLE. stall_req_out is 1 in FETCH and 0 in DONE.
- ce_in=0 in IDLE: inst_valid_out=0, no RAM request.
- stall[1]=1: inst_out, inst_pc_out and inst_valid_out hold their values. The FSM may still complete a fetch but holds in DONE until stall[1]=0.
- branch_flag_in=1, any state: the next edge forces IDLE and inst_valid_out=0. Partial bytes are discarded, the cache is not written, and a pending byte arriving next cycle is ignored. Branch takes priority over stall[1].
- mem_grant_in=0 mid-fetch: no new address is issued and the issue count freezes. A byte already pending is still captured.
- mem_wr_out is tied to 0.

## Timing
- Reset values (asynchronous): state IDLE, all cache valid bits 0, all outputs 0, counts 0, pending 0.
- Hit latency: 1 cycle from pc_in/ce_in to inst_valid_out.
- Miss latency with continuous grant:
  - Addresses issued in cycles 0–3 (cycle 0 = miss detection).
  - Bytes captured at the edges ending cycles 1–4.
  - DONE in cycle 5; inst_valid_out=1 from cycle 6.
  - stall_req_out high in cycles 0–4.
- Each cycle with mem_grant_in low extends the miss latency by one.
- Fetch address wrap: fetch_pc + 3 wraps modulo 2^32.
- Reset asserted mid-fetch: immediate return to IDLE; outputs and valid bits cleared.

## Test plan
- Reset, then ce_in=1, pc_in=0x0 on a cold cache, with RAM bytes 0x13,0x05,0x00,0x00: mem_a_out runs 0x0..0x3, stall_req_out is high for 5 cycles, then inst_out=0x00000513, inst_pc_out=0x0 and inst_valid_out=1.
- Refetch pc_in=0x0: hit, inst_out=0x00000513 one cycle later, no mem_req_out, stall_req_out stays 0.
- Miss at 0x100 with mem_grant_in low for 2 cycles after the second address: the address sequence pauses, the byte already pending is captured, and the instruction is delivered 2 cycles late and correct.
- branch_flag_in pulsed during the third byte of a miss at 0x200: the next cycle is IDLE with inst_valid_out=0. A later fetch of 0x200 misses, showing the line was not written.
- stall[1]=1 while DONE is reached: outputs hold their previous values. After release, the new instruction appears.
- rst_n_in low during FETCH: all outputs are 0 immediately. A fetch of the previously cached 0x0 then misses.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch responder: direct-mapped I-cache in front of a byte-wide RAM port,
// assembling misses from four sequential byte reads while holding the PC via stall_req_out.
module if_fetch #(
  parameter int ICACHE_IDX = 6
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ce_in,
  input  logic [31:0] pc_in,
  input  logic        branch_flag_in,
  input  logic [5:0]  stall,
  input  logic        mem_grant_in,
  input  logic [7:0]  mem_din_in,
  output logic        mem_req_out,
  output logic [31:0] mem_a_out,
  output logic        mem_wr_out,
  output logic        stall_req_out,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out
);
  localparam int LINES = 1 << ICACHE_IDX;
  localparam int TAG_W = 30 - ICACHE_IDX;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } line_t;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [2:0]        iss_cnt_q, iss_cnt_d;
  logic [1:0]        rcv_cnt_q, rcv_cnt_d;
  logic              pend_q, pend_d;
  logic [3:0][7:0]   buf_q, buf_d;
  logic [LINES-1:0]  vld_q, vld_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  line_t             line_q [LINES];

  logic                  wr_en;
  logic [ICACHE_IDX-1:0] wr_idx;
  line_t                 wr_line;
  logic [ICACHE_IDX-1:0] idx;
  logic [TAG_W-1:0]      tag;
  line_t                 rd_line;
  logic                  hit;
  logic                  id_stall;
  logic                  unused_stall;

  assign idx          = pc_in[ICACHE_IDX+1:2];
  assign tag          = pc_in[31:ICACHE_IDX+2];
  assign rd_line      = line_q[idx];
  assign hit          = vld_q[idx] && (rd_line.tag == tag);
  assign id_stall     = stall[1];
  assign unused_stall = ^{stall[5:2], stall[0]};
  assign mem_wr_out   = 1'b0;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    iss_cnt_d     = iss_cnt_q;
    rcv_cnt_d     = rcv_cnt_q;
    pend_d        = 1'b0;
    buf_d         = buf_q;
    vld_d         = vld_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    wr_en         = 1'b0;
    wr_idx        = fetch_pc_q[ICACHE_IDX+1:2];
    mem_req_out   = 1'b0;
    mem_a_out     = '0;
    stall_req_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_in) begin
          if (hit) begin
            if (!id_stall) begin
              inst_d       = rd_line.data;
              inst_pc_d    = pc_in;
              inst_valid_d = 1'b1;
            end
          end else begin
            // First byte goes out in the detection cycle itself
            stall_req_out = 1'b1;
            mem_req_out   = 1'b1;
            mem_a_out     = pc_in;
            fetch_pc_d    = pc_in;
            rcv_cnt_d     = 2'd0;
            iss_cnt_d     = {2'b00, mem_grant_in};
            pend_d        = mem_grant_in;
            state_d       = FETCH;
          end
        end else if (!id_stall) begin
          inst_valid_d = 1'b0;
        end
      end
      FETCH: begin
        stall_req_out = 1'b1;
        if (iss_cnt_q < 3'd4) begin
          mem_req_out = 1'b1;
          mem_a_out   = fetch_pc_q + {29'b0, iss_cnt_q};
          if (mem_grant_in) begin
            iss_cnt_d = iss_cnt_q + 3'd1;
            pend_d    = 1'b1;
          end
        end
        if (pend_q) begin
          buf_d[rcv_cnt_q] = mem_din_in;
          rcv_cnt_d        = rcv_cnt_q + 2'd1;
          if (rcv_cnt_q == 2'd3) begin
            wr_en         = 1'b1;
            vld_d[wr_idx] = 1'b1;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        if (!id_stall) begin
          inst_d       = buf_q;
          inst_pc_d    = fetch_pc_q;
          inst_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including an ID stall and a completing line fill
    if (branch_flag_in) begin
      state_d      = IDLE;
      inst_valid_d = 1'b0;
      pend_d       = 1'b0;
      wr_en        = 1'b0;
      vld_d        = vld_q;
      mem_req_out  = 1'b0;
      mem_a_out    = '0;
    end
    wr_line.tag  = fetch_pc_q[31:ICACHE_IDX+2];
    wr_line.data = buf_d;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      fetch_pc_q   <= '0;
      iss_cnt_q    <= '0;
      rcv_cnt_q    <= '0;
      pend_q       <= 1'b0;
      buf_q        <= '0;
      vld_q        <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      iss_cnt_q    <= iss_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      pend_q       <= pend_d;
      buf_q        <= buf_d;
      vld_q        <= vld_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Tag/data store needs no reset; vld_q gates every read
  always_ff @(posedge clk_in) begin
    if (wr_en) line_q[wr_idx] <= wr_line;
  end

  assign inst_valid_out = inst_valid_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = inst_pc_q;
endmodule
